// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: memory bus widths,
// the bubble instruction word and the fetch FSM state encoding.
package inst_fetch_pkg;

  // RAM2 address and data widths
  localparam int MEM_ADDR_W  = 18;
  localparam int MEM_VALUE_W = 16;

  // Instruction word placed in IF/ID when no real instruction is available
  localparam logic [15:0] NOP_INST_WORD = 16'h0800;

  // FETCH: request outstanding, waiting for RAM2.
  // HOLD:  one word captured while ID was stalled; no request outstanding.
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } if_state_e;

endpackage

// File: rtl/inst_fetch_buf.sv
// One-entry skid buffer for the fetch stage. It captures a word that arrives
// while ID is stalled and presents it until it is drained or a redirect
// invalidates it.
module inst_fetch_buf
  import inst_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_clear,
  input  logic [MEM_VALUE_W-1:0] i_inst,
  input  logic [15:0]            i_pc,
  output logic [MEM_VALUE_W-1:0] o_inst,
  output logic [15:0]            o_pc,
  output logic                   o_valid
);

  logic [MEM_VALUE_W-1:0] r_inst;
  logic [15:0]            r_pc;
  logic                   r_valid;

  // Occupancy flag: reset and clear win over a new load
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end
  end

  // Payload is only meaningful while r_valid is set, so it carries no reset
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_inst <= i_inst;
      r_pc   <= i_pc;
    end
  end

  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage in front of the RAM2 controller. Owns the PC, issues
// fetch requests, fills the IF/ID latch, and parks one word in a skid buffer
// when ID stalls. Redirects take priority over stalls and completions.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = NOP_INST_WORD,
  parameter int          ADDR_W   = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_target,
  input  logic              if_work_done,
  input  logic [15:0]       if_result,
  output logic              need_to_work_if,
  output logic [ADDR_W-1:0] mem_addr_if,
  output logic [15:0]       id_inst,
  output logic [15:0]       id_pc,
  output logic              id_valid,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       wait_cnt
);

  if_state_e   r_state;
  logic [15:0] r_pc;
  logic [15:0] r_id_inst;
  logic [15:0] r_id_pc;
  logic        r_id_valid;
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_wait_cnt;

  logic        w_buf_load;
  logic        w_buf_clear;
  logic [15:0] w_buf_inst;
  logic [15:0] w_buf_pc;
  logic        w_buf_valid;

  // A completion during a stall is parked; a redirect or a drain empties the buffer
  assign w_buf_load  = rst && !branch_taken && (r_state == FETCH) && if_work_done && stall;
  assign w_buf_clear = branch_taken || ((r_state == HOLD) && !stall);

  inst_fetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_inst  (if_result),
    .i_pc    (r_pc),
    .o_inst  (w_buf_inst),
    .o_pc    (w_buf_pc),
    .o_valid (w_buf_valid)
  );

  // Fetch FSM with PC, IF/ID latch and counters; priority rst > redirect > stall > done
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_id_inst   <= NOP_INST;
      r_id_pc     <= 16'h0000;
      r_id_valid  <= 1'b0;
      r_fetch_cnt <= 16'h0000;
      r_wait_cnt  <= 16'h0000;
    end else if (branch_taken) begin
      // Any in-flight or buffered word belongs to the wrong path
      r_state <= FETCH;
      r_pc    <= branch_target;
      if (!stall) begin
        r_id_inst  <= NOP_INST;
        r_id_valid <= 1'b0;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (if_work_done && !stall) begin
            r_id_inst   <= if_result;
            r_id_pc     <= r_pc;
            r_id_valid  <= 1'b1;
            r_pc        <= r_pc + 16'd1;
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
          end else if (if_work_done) begin
            // ID is stalled: the word went into the skid buffer, PC stays put
            r_state <= HOLD;
          end else begin
            if (!stall) begin
              r_id_inst  <= NOP_INST;
              r_id_valid <= 1'b0;
            end
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        HOLD: begin
          if (!stall && w_buf_valid) begin
            r_id_inst   <= w_buf_inst;
            r_id_pc     <= w_buf_pc;
            r_id_valid  <= 1'b1;
            r_pc        <= r_pc + 16'd1;
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
            r_state     <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  // Request drops immediately while reset is held so RAM2 never sees a stale fetch
  assign need_to_work_if = (r_state == FETCH) && rst;
  assign mem_addr_if     = {{(ADDR_W-16){1'b0}}, r_pc};
  assign id_inst         = r_id_inst;
  assign id_pc           = r_id_pc;
  assign id_valid        = r_id_valid;
  assign fetch_cnt       = r_fetch_cnt;
  assign wait_cnt        = r_wait_cnt;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random traffic,
// compared each cycle against a transaction-level reference model.
module tb_inst_fetch;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        if_work_done;
  logic [15:0] if_result;
  logic        need_to_work_if;
  logic [17:0] mem_addr_if;
  logic [15:0] id_inst;
  logic [15:0] id_pc;
  logic        id_valid;
  logic [15:0] fetch_cnt;
  logic [15:0] wait_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: "parked" holds the word captured during a stall (0 or 1 entries)
  typedef struct packed { logic [15:0] word; logic [15:0] pc; } parked_t;
  parked_t     parked[$];
  logic [15:0] m_pc, m_inst, m_idpc, m_fc, m_wc;
  logic        m_valid;
  logic [15:0] salt;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .if_work_done    (if_work_done),
    .if_result       (if_result),
    .need_to_work_if (need_to_work_if),
    .mem_addr_if     (mem_addr_if),
    .id_inst         (id_inst),
    .id_pc           (id_pc),
    .id_valid        (id_valid),
    .fetch_cnt       (fetch_cnt),
    .wait_cnt        (wait_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents as a function of address
  function automatic logic [15:0] word_at(input logic [15:0] a);
    return (a * 16'h9e37) ^ salt;
  endfunction

  function automatic bit m_fetching();
    return parked.size() == 0;
  endfunction

  task automatic deliver(input logic [15:0] w, input logic [15:0] p);
    m_inst  = w;
    m_idpc  = p;
    m_valid = 1'b1;
    m_pc    = m_pc + 16'd1;
    m_fc    = m_fc + 16'd1;
  endtask

  // Advance the model by one clock using the inputs that were applied
  task automatic model_step();
    parked_t e;
    if (!rst) begin
      parked.delete();
      m_pc = 16'h0000; m_inst = NOP; m_idpc = 16'h0000; m_valid = 1'b0;
      m_fc = 16'h0000; m_wc = 16'h0000;
    end else if (branch_taken) begin
      parked.delete();
      m_pc = branch_target;
      if (!stall) begin m_inst = NOP; m_valid = 1'b0; end
    end else if (!m_fetching()) begin
      if (!stall) begin
        e = parked.pop_front();
        deliver(e.word, e.pc);
      end
    end else if (if_work_done) begin
      if (!stall) deliver(word_at(m_pc), m_pc);
      else parked.push_back('{word: word_at(m_pc), pc: m_pc});
    end else begin
      if (!stall) begin m_inst = NOP; m_valid = 1'b0; end
      m_wc = m_wc + 16'd1;
    end
  endtask

  // One cycle: apply inputs after the falling edge, compare, then clock the model
  task automatic cyc(input logic r, input logic st, input logic br, input logic [15:0] tgt,
                     input logic dn, input bit chk);
    @(negedge clk);
    rst           = r;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    if_work_done  = dn;
    if_result     = dn ? word_at(m_pc) : 16'($urandom);
    #1;
    if (chk) begin
      check_eq("req",       {31'd0, need_to_work_if}, {31'd0, m_fetching() && r});
      check_eq("mem_addr",  {14'd0, mem_addr_if}, {16'd0, m_pc});
      check_eq("id_inst",   {16'd0, id_inst}, {16'd0, m_inst});
      check_eq("id_pc",     {16'd0, id_pc}, {16'd0, m_idpc});
      check_eq("id_valid",  {31'd0, id_valid}, {31'd0, m_valid});
      check_eq("fetch_cnt", {16'd0, fetch_cnt}, {16'd0, m_fc});
      check_eq("wait_cnt",  {16'd0, wait_cnt}, {16'd0, m_wc});
    end
    @(posedge clk);
    model_step();
  endtask

  int guard;

  initial begin
    salt = 16'($urandom);
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    if_work_done = 1'b0; if_result = '0;
    m_pc = '0; m_inst = NOP; m_idpc = '0; m_valid = 1'b0; m_fc = '0; m_wc = '0;

    // 1: reset, then a completion every 4th cycle
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 1'b0, 1'b0, 16'h0, (i % 4) == 3, 1'b1);
    #1;
    check_eq("t1_fetch_cnt", {16'd0, fetch_cnt}, 32'd4);
    check_eq("t1_last_pc", {16'd0, id_pc}, 32'd3);

    // 2: word at pc 5 arrives during a 3-cycle stall, then drains
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    check_eq("t2_hold_req", {31'd0, need_to_work_if}, 32'd0);
    check_eq("t2_hold_idpc", {16'd0, id_pc}, 32'd4);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    #1;
    check_eq("t2_id_inst", {16'd0, id_inst}, {16'd0, word_at(16'd5)});
    check_eq("t2_id_pc", {16'd0, id_pc}, 32'd5);
    check_eq("t2_pc", {14'd0, mem_addr_if}, 32'd6);

    // 3: redirect in the same cycle as the completion at pc 9
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b1);
    #1;
    check_eq("t3_valid", {31'd0, id_valid}, 32'd0);
    check_eq("t3_addr", {14'd0, mem_addr_if}, 32'h40);

    // 4: redirect while a word is parked
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b1);
    #1;
    check_eq("t4_fetch_cnt", {16'd0, fetch_cnt}, 32'd9);
    check_eq("t4_req", {31'd0, need_to_work_if}, 32'd1);
    check_eq("t4_addr", {14'd0, mem_addr_if}, 32'h100);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    check_eq("t4_first_pc", {16'd0, id_pc}, 32'h100);

    // 6: reset during a fetch wait at pc 0x22
    cyc(1'b1, 1'b0, 1'b1, 16'h0022, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    check_eq("t6_req_in_reset", {31'd0, need_to_work_if}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    check_eq("t6_pc", {14'd0, mem_addr_if}, 32'd0);
    check_eq("t6_cnt", {fetch_cnt, wait_cnt}, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 19) == 0), 16'($urandom),
          ($urandom_range(0, 9) < 4), 1'b1);

    // 5: back-to-back delivery from reset; pc and fetch_cnt wrap together at 0xffff
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    guard = 0;
    while (m_fc != 16'hffff && guard < 70000) begin
      cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, (guard % 4096) == 0);
      guard++;
    end
    check_eq("t5_reach", {16'd0, m_pc}, 32'hffff);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    check_eq("t5_wrap_addr", {14'd0, mem_addr_if}, 32'd0);
    check_eq("t5_wrap_cnt", {16'd0, fetch_cnt}, 32'd0);
    check_eq("t5_last_pc", {16'd0, id_pc}, 32'hffff);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
